// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serdes_pkg
// Brief    : Shared types and helpers for the SerDes link controller:
//            TX/RX state encodings, default payload width, counter sizing.
// Revision : 1.0 - initial release
// ============================================================================
package serdes_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_HUNT  = 3'd0,
        RX_IDLE  = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_t;

    // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : serdes_pkg
`default_nettype wire

// File: rtl/serdes_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : serdes_rx_deframer
// Brief    : Receive half of the SerDes link: 2-flop input synchronizer,
//            start/data/parity/stop deframing FSM, parity and framing checks.
// Revision : 1.0 - initial release
// ============================================================================
module serdes_rx_deframer
    import serdes_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_en,
    input  logic              par_en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_par_err,
    output logic              rx_frame_err
);

    localparam int                CNT_W       = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0]  c_last_data = CNT_W'(DATA_W - 1);

    logic              r_sync1;
    logic              r_sync2;
    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              r_par_bit;
    logic              w_par_bit_nxt;
    logic              r_par_en;
    logic              w_par_en_nxt;
    logic [DATA_W-1:0] r_rx_data;
    logic [DATA_W-1:0] w_rx_data_nxt;
    logic              r_rx_valid;
    logic              r_rx_par_err;
    logic              r_rx_frame_err;
    logic              w_valid_nxt;
    logic              w_par_err_nxt;
    logic              w_frame_err_nxt;
    logic              w_line;

    assign w_line = r_sync2;

    // Two-stage synchronizer; resets to the idle-high line level and keeps
    // running even while the link is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= ser_in;
            r_sync2 <= r_sync1;
        end
    end

    // Deframer state, shift register and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RX_HUNT;
            r_cnt          <= '0;
            r_shift        <= '0;
            r_par_bit      <= 1'b0;
            r_par_en       <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_par_err   <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_shift        <= w_shift_nxt;
            r_par_bit      <= w_par_bit_nxt;
            r_par_en       <= w_par_en_nxt;
            r_rx_data      <= w_rx_data_nxt;
            r_rx_valid     <= w_valid_nxt;
            r_rx_par_err   <= w_par_err_nxt;
            r_rx_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state: the state names the bit the synchronized line carries now.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_par_bit_nxt   = r_par_bit;
        w_par_en_nxt    = r_par_en;
        w_rx_data_nxt   = r_rx_data;
        w_valid_nxt     = 1'b0;
        w_par_err_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;
        if (!ser_en) begin
            // Disabled: drop any partial frame and require idle line again.
            w_state_nxt = RX_HUNT;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                RX_HUNT: begin
                    if (w_line) begin
                        w_state_nxt = RX_IDLE;
                    end
                end
                RX_IDLE: begin
                    if (!w_line) begin
                        w_state_nxt  = RX_DATA;
                        w_cnt_nxt    = '0;
                        w_par_en_nxt = par_en;
                    end
                end
                RX_DATA: begin
                    w_shift_nxt = {w_line, r_shift[DATA_W-1:1]};
                    if (r_cnt == c_last_data) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = r_par_en ? RX_PAR : RX_STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                RX_PAR: begin
                    w_par_bit_nxt = w_line;
                    w_state_nxt   = RX_STOP;
                end
                RX_STOP: begin
                    if (w_line) begin
                        if (r_par_en && (r_par_bit != (^r_shift))) begin
                            w_par_err_nxt = 1'b1;
                        end else begin
                            w_rx_data_nxt = r_shift;
                            w_valid_nxt   = 1'b1;
                        end
                        w_state_nxt = RX_IDLE;
                    end else begin
                        // A low stop bit means we may be mid-character; resync.
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = RX_HUNT;
                    end
                end
                default: begin
                    w_state_nxt = RX_HUNT;
                end
            endcase
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_par_err   = r_rx_par_err;
    assign rx_frame_err = r_rx_frame_err;

endmodule : serdes_rx_deframer
`default_nettype wire

// File: rtl/serdes_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serdes_link_ctrl
// Brief    : Link-layer controller for a 1-bit SerDes lane. Frames bytes from
//            a valid/ready interface onto ser_out and deframes ser_in.
// Revision : 1.0 - initial release
// ============================================================================
module serdes_link_ctrl
    import serdes_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_en,
    input  logic              par_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    input  logic              ser_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_par_err,
    output logic              rx_frame_err
);

    localparam int               CNT_W       = cnt_width((DATA_W > STOP_BITS) ? DATA_W : STOP_BITS);
    localparam logic [CNT_W-1:0] c_last_data = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_last_stop = CNT_W'(STOP_BITS - 1);

    tx_state_t         r_tx_state;
    tx_state_t         w_tx_state_nxt;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic [CNT_W-1:0]  w_tx_cnt_nxt;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_par;
    logic              r_ser_out;
    logic              w_ser_out_nxt;
    logic              w_tx_last_stop;
    logic              w_tx_ready;
    logic              w_tx_fire;

    // Ready in idle or on the final stop cycle so frames can abut; held low
    // while reset is asserted.
    assign w_tx_last_stop = (r_tx_state == TX_STOP) && (r_tx_cnt == c_last_stop);
    assign w_tx_ready     = ser_en & rst_n & ((r_tx_state == TX_IDLE) | w_tx_last_stop);
    assign w_tx_fire      = tx_valid & w_tx_ready;

    // TX state, bit counter, registered lane output and frame capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_ser_out  <= 1'b1;
            r_tx_data  <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_ser_out  <= w_ser_out_nxt;
            if (w_tx_fire) begin
                r_tx_data <= tx_data;
                r_tx_par  <= par_en;
            end
        end
    end

    // Next-state and next lane bit; ser_out is derived from the next state so
    // the registered output and the state register stay aligned.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_ser_out_nxt  = 1'b1;
        if (!ser_en) begin
            w_tx_state_nxt = TX_IDLE;
            w_tx_cnt_nxt   = '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_fire) begin
                        w_tx_state_nxt = TX_START;
                        w_tx_cnt_nxt   = '0;
                    end
                end
                TX_START: begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_cnt_nxt   = '0;
                end
                TX_DATA: begin
                    if (r_tx_cnt == c_last_data) begin
                        w_tx_cnt_nxt   = '0;
                        w_tx_state_nxt = r_tx_par ? TX_PAR : TX_STOP;
                    end else begin
                        w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                    end
                end
                TX_PAR: begin
                    w_tx_state_nxt = TX_STOP;
                    w_tx_cnt_nxt   = '0;
                end
                TX_STOP: begin
                    if (r_tx_cnt == c_last_stop) begin
                        w_tx_cnt_nxt   = '0;
                        w_tx_state_nxt = w_tx_fire ? TX_START : TX_IDLE;
                    end else begin
                        w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    w_tx_state_nxt = TX_IDLE;
                    w_tx_cnt_nxt   = '0;
                end
            endcase
        end

        case (w_tx_state_nxt)
            TX_START: w_ser_out_nxt = 1'b0;
            TX_DATA:  w_ser_out_nxt = r_tx_data[w_tx_cnt_nxt];
            TX_PAR:   w_ser_out_nxt = ^r_tx_data;
            default:  w_ser_out_nxt = 1'b1;
        endcase
    end

    assign tx_ready = w_tx_ready;
    assign ser_out  = r_ser_out;

    serdes_rx_deframer #(
        .DATA_W (DATA_W)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .ser_en       (ser_en),
        .par_en       (par_en),
        .ser_in       (ser_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_par_err   (rx_par_err),
        .rx_frame_err (rx_frame_err)
    );

endmodule : serdes_link_ctrl
`default_nettype wire

// File: tb/tb_serdes_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serdes_link_ctrl
// Brief    : Self-checking bench for serdes_link_ctrl: TX framing, loopback
//            reception, error frames, reset and link-enable behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serdes_link_ctrl;

    localparam logic [1:0] c_ev_valid = 2'd0;
    localparam logic [1:0] c_ev_par   = 2'd1;
    localparam logic [1:0] c_ev_frame = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_en;
    logic       par_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ser_out;
    logic       ser_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_par_err;
    logic       rx_frame_err;

    logic       loop_en;
    logic       drv_ser;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    ev_t        exp_q[$];
    int         valid_times[$];

    ev_t        mon_e;
    logic [1:0] mon_kind;
    int         mon_hot;

    assign ser_in = loop_en ? ser_out : drv_ser;

    serdes_link_ctrl #(
        .DATA_W    (8),
        .STOP_BITS (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ser_en       (ser_en),
        .par_en       (par_en),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .ser_out      (ser_out),
        .ser_in       (ser_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_par_err   (rx_par_err),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every status pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || rx_par_err || rx_frame_err)) begin
            mon_hot  = int'(rx_valid) + int'(rx_par_err) + int'(rx_frame_err);
            mon_kind = rx_valid ? c_ev_valid : (rx_par_err ? c_ev_par : c_ev_frame);
            n_checks++;
            if (mon_hot != 1) begin
                n_fail++;
                $display("FAIL rx_onehot: %0d pulses high, required 1", mon_hot);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_unexpected: kind %0d data %02h, required no event", mon_kind, rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_kind !== mon_e.kind || (mon_e.kind == c_ev_valid && rx_data !== mon_e.data)) begin
                    n_fail++;
                    $display("FAIL rx_event: kind %0d data %02h, required kind %0d data %02h",
                             mon_kind, rx_data, mon_e.kind, mon_e.data);
                end
            end
            if (rx_valid) valid_times.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Drives start, LSB-first data, parity bit and stop bit on the lane.
    task automatic send_serial(input logic [7:0] d, input logic pbit, input logic stop);
        logic [10:0] bits;
        bits = {stop, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drv_ser = bits[i];
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        ser_en   = 1'b1;
        par_en   = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        loop_en  = 1'b1;
        drv_ser  = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b0 || ser_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx: tx_ready %b ser_out %b, required 0 1", tx_ready, ser_out);
        end
        n_checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_par_err !== 1'b0 || rx_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rx: data %02h v %b p %b f %b, required 00 0 0 0",
                     rx_data, rx_valid, rx_par_err, rx_frame_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: tx_ready %b, required 1", tx_ready);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loopback;
        logic [10:0] exp_bits;
        int          t0;
        bit          ok;
        valid_times.delete();
        wait_ready(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL loop_ready: tx_ready 0, required 1");
        end
        exp_bits = {1'b1, ^8'hA5, 8'hA5, 1'b0};
        t0       = cyc;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        exp_q.push_back('{kind: c_ev_valid, data: 8'hA5});
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            n_checks++;
            if (ser_out !== exp_bits[i]) begin
                n_fail++;
                $display("FAIL loop_ser_out bit %0d: got %b, required %b", i, ser_out, exp_bits[i]);
            end
        end
        wait_drain(20);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL loop_drain: %0d events pending, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (valid_times.size() != 1 || valid_times[0] - t0 != 14) begin
            n_fail++;
            $display("FAIL loop_latency: %0d pulses, first at %0d, required 1 at 14",
                     valid_times.size(), (valid_times.size() > 0) ? valid_times[0] - t0 : -1);
        end
        n_checks++;
        if (rx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL loop_rx_data: got %02h, required a5", rx_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        wait_ready(ok);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ser_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_pre: ser_out %b, required 0", ser_out);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ser_out !== 1'b1 || tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async_tx: ser_out %b tx_ready %b, required 1 0", ser_out, tx_ready);
        end
        n_checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_par_err !== 1'b0 || rx_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async_rx: data %02h v %b p %b f %b, required 00 0 0 0",
                     rx_data, rx_valid, rx_par_err, rx_frame_err);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_hold_ready: tx_ready %b, required 0", tx_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1 || ser_out !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_release: tx_ready %b ser_out %b, required 1 1", tx_ready, ser_out);
        end
        repeat (16) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        int         xfer [3];
        bit         ok;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h3C;
        valid_times.delete();
        tx_data  = bytes[0];
        tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready(ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL b2b_ready %0d: timed out, required tx_ready", k);
            end
            xfer[k] = cyc;
            exp_q.push_back('{kind: c_ev_valid, data: bytes[k]});
            @(negedge clk);
            n_checks++;
            if (ser_out !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_start %0d: ser_out %b, required 0", k, ser_out);
            end
            if (k < 2) tx_data = bytes[k+1];
            else       tx_valid = 1'b0;
        end
        n_checks++;
        if (xfer[1] - xfer[0] != 11 || xfer[2] - xfer[1] != 11) begin
            n_fail++;
            $display("FAIL b2b_gap: spacing %0d %0d, required 11 11", xfer[1] - xfer[0], xfer[2] - xfer[1]);
        end
        wait_drain(40);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d events pending, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (valid_times.size() != 3 || valid_times[1] - valid_times[0] != 11 ||
            valid_times[2] - valid_times[1] != 11) begin
            n_fail++;
            $display("FAIL b2b_rx_spacing: %0d pulses, required 3 pulses 11 apart", valid_times.size());
        end
    endtask

    task automatic test_par_err;
        loop_en = 1'b0;
        drv_ser = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back('{kind: c_ev_par, data: 8'h00});
        send_serial(8'h01, 1'b0, 1'b1);
        @(negedge clk);
        drv_ser = 1'b1;
        wait_drain(20);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL par_drain: %0d events pending, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (rx_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL par_rx_data: got %02h, required 3c", rx_data);
        end
    endtask

    task automatic test_frame_err;
        exp_q.push_back('{kind: c_ev_frame, data: 8'h00});
        send_serial(8'h55, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        drv_ser = 1'b1;
        wait_drain(10);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL frame_drain: %0d events pending, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (rx_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL frame_rx_data_hold: got %02h, required 3c", rx_data);
        end
        exp_q.push_back('{kind: c_ev_valid, data: 8'h5A});
        send_serial(8'h5A, ^8'h5A, 1'b1);
        @(negedge clk);
        drv_ser = 1'b1;
        wait_drain(20);
        n_checks++;
        if (exp_q.size() != 0 || rx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL frame_recover: pending %0d data %02h, required 0 5a", exp_q.size(), rx_data);
            exp_q.delete();
        end
    endtask

    task automatic test_ser_en_drop;
        bit ok;
        loop_en = 1'b1;
        repeat (3) @(negedge clk);
        wait_ready(ok);
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (ser_out !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_bit4: ser_out %b, required 0", ser_out);
        end
        ser_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ser_out !== 1'b1 || tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_next: ser_out %b tx_ready %b, required 1 0", ser_out, tx_ready);
        end
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if (ser_out !== 1'b1) begin
                n_fail++;
                $display("FAIL drop_idle %0d: ser_out %b, required 1", i, ser_out);
            end
        end
        ser_en  = 1'b1;
        tx_data = 8'h81;
        #1;
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_reenable_ready: tx_ready %b, required 1", tx_ready);
        end
        exp_q.push_back('{kind: c_ev_valid, data: 8'h81});
        @(negedge clk);
        tx_valid = 1'b0;
        wait_drain(30);
        n_checks++;
        if (exp_q.size() != 0 || rx_data !== 8'h81) begin
            n_fail++;
            $display("FAIL drop_recover: pending %0d data %02h, required 0 81", exp_q.size(), rx_data);
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_reset_mid_frame();
        test_back_to_back();
        test_par_err();
        test_frame_err();
        test_ser_en_drop();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serdes_link_ctrl
`default_nettype wire
